// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential signed Booth multiplier.
// One Booth recoding step per clock. The exact 2*WIDTH-bit signed product is
// presented with a one-cycle done pulse.
//
// Optional macro BOOTH_RADIX4_EN selects modified-Booth radix-4 recoding.
// That mode takes WIDTH/2 steps and needs WIDTH even. Without the macro the
// block uses radix-2 recoding and takes WIDTH steps.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         request; sampled only while idle
//   multiplicand  signed operand A (WIDTH bits), sampled with start
//   multiplier    signed operand B (WIDTH bits), sampled with start
//   busy          high while an operation is in progress
//   done          one-cycle pulse when product is updated
//   product       signed A*B (2*WIDTH bits); holds until the next completion
module booth_mult_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // Two guard bits keep -2^(W-1) operands and the +-2A radix-4 addend exact.
    localparam int unsigned HW = WIDTH + 2;
`ifdef BOOTH_RADIX4_EN
    localparam int unsigned NSTEP = WIDTH / 2;
`else
    localparam int unsigned NSTEP = WIDTH;
`endif
    localparam int unsigned CW = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    // Parameter legality checks, reported at elaboration.
    if (WIDTH < 4) begin : g_chk_min
        $error("booth_mult_seq: WIDTH must be >= 4");
    end
`ifdef BOOTH_RADIX4_EN
    if ((WIDTH % 2) != 0) begin : g_chk_even
        $error("booth_mult_seq: WIDTH must be even with BOOTH_RADIX4_EN");
    end
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q, state_nxt;
    logic [HW-1:0]        a_q, a_nxt;
    logic [HW-1:0]        hi_q, hi_nxt;
    logic [WIDTH-1:0]     lo_q, lo_nxt;
    logic                 e_q, e_nxt;
    logic [CW-1:0]        cnt_q, cnt_nxt;
    logic                 busy_q, busy_nxt;
    logic                 done_q, done_nxt;
    logic [2*WIDTH-1:0]   prod_q, prod_nxt;

    logic [HW-1:0]        addend;
    logic [HW-1:0]        sum;
    logic [HW-1:0]        step_hi;
    logic [WIDTH-1:0]     step_lo;
    logic                 step_e;

    // One recoding step: select addend, add into the high half, shift right.
    always_comb begin
        addend  = '0;
`ifdef BOOTH_RADIX4_EN
        case ({lo_q[1], lo_q[0], e_q})
            3'b001, 3'b010: addend = a_q;
            3'b011:         addend = {a_q[HW-2:0], 1'b0};
            3'b100:         addend = -{a_q[HW-2:0], 1'b0};
            3'b101, 3'b110: addend = -a_q;
            default:        addend = '0;
        endcase
        sum     = hi_q + addend;
        step_hi = {{2{sum[HW-1]}}, sum[HW-1:2]};
        step_lo = {sum[1:0], lo_q[WIDTH-1:2]};
        step_e  = lo_q[1];
`else
        case ({lo_q[0], e_q})
            2'b01:   addend = a_q;
            2'b10:   addend = -a_q;
            default: addend = '0;
        endcase
        sum     = hi_q + addend;
        step_hi = {sum[HW-1], sum[HW-1:1]};
        step_lo = {sum[0], lo_q[WIDTH-1:1]};
        step_e  = lo_q[0];
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt = state_q;
        a_nxt     = a_q;
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        e_nxt     = e_q;
        cnt_nxt   = cnt_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        prod_nxt  = prod_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    a_nxt     = {{2{multiplicand[WIDTH-1]}}, multiplicand};
                    hi_nxt    = '0;
                    lo_nxt    = multiplier;
                    e_nxt     = 1'b0;
                    cnt_nxt   = CW'(NSTEP - 1);
                    busy_nxt  = 1'b1;
                end
            end
            RUN: begin
                hi_nxt = step_hi;
                lo_nxt = step_lo;
                e_nxt  = step_e;
                if (cnt_q == '0) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    prod_nxt  = {step_hi[WIDTH-1:0], step_lo};
                end else begin
                    cnt_nxt = cnt_q - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            e_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_nxt;
            a_q     <= a_nxt;
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
            e_q     <= e_nxt;
            cnt_q   <= cnt_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            prod_q  <= prod_nxt;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

    localparam int unsigned W = 8;
`ifdef BOOTH_RADIX4_EN
    localparam int N = W / 2;
`else
    localparam int N = W;
`endif

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks   = 0;
    int failures = 0;
    int overlap  = 0;

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && done && busy) overlap++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait up to a bounded number of edges for done; returns edges waited.
    task automatic wait_done(output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        while (!got && lat < N + 8) begin
            @(posedge clk); #1;
            lat++;
            if (done) got = 1'b1;
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp);
        int lat;
        @(negedge clk);
        start = 1'b1; multiplicand = a; multiplier = b;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        check({tag, "_lat"}, 64'(lat), 64'(N));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_prod"}, 64'(product), 64'(exp));
    endtask

    initial begin
        int lat;
        int pulses;
        logic [2*W-1:0] seen;
        logic signed [W-1:0] ra, rb;
        logic signed [2*W-1:0] rp;

        rst_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_prod", 64'(product), 64'(0));
        @(negedge clk); rst_n = 1'b1;

        do_op("p7xm3", 8'd7, 8'hFD, 16'hFFEB);
        do_op("m128xm128", 8'h80, 8'h80, 16'h4000);
        do_op("m128x127", 8'h80, 8'h7F, 16'hC080);
        do_op("m1x1", 8'hFF, 8'h01, 16'hFFFF);
        do_op("p127x127", 8'h7F, 8'h7F, 16'h3F01);

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1; multiplicand = 8'h00; multiplier = 8'hFF;
        @(posedge clk); #1;
        @(negedge clk); multiplicand = 8'hFF; multiplier = 8'hFF;
        wait_done(lat);
        check("b2b1_lat", 64'(lat), 64'(N));
        check("b2b1_prod", 64'(product), 64'(16'h0000));
        @(posedge clk); #1;
        check("b2b_cap_busy", 64'(busy), 64'(1));
        check("b2b_cap_done", 64'(done), 64'(0));
        start = 1'b0;
        wait_done(lat);
        check("b2b2_lat", 64'(lat), 64'(N));
        check("b2b2_prod", 64'(product), 64'(16'h0001));

        // Start pulse during an operation is ignored.
        @(negedge clk);
        start = 1'b1; multiplicand = 8'd7; multiplier = 8'hFD;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0; seen = '0;
        for (int i = 1; i <= N + 6; i++) begin
            @(posedge clk); #1;
            if (done) begin pulses++; seen = product; end
            if (i == 3) begin start = 1'b1; multiplicand = 8'd5; multiplier = 8'd5; end
            if (i == 4) start = 1'b0;
        end
        check("ign_pulses", 64'(pulses), 64'(1));
        check("ign_prod", 64'(seen), 64'(16'hFFEB));

        // Reset mid-operation.
        @(negedge clk);
        start = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b0; #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_prod", 64'(product), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        check("post_rst_idle", 64'(pulses), 64'(0));
        do_op("post_rst_op", 8'hF6, 8'd12, 16'hFF88);

        // Random sweep against the signed reference product.
        for (int k = 0; k < 2000; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rp = ra * rb;
            do_op("rand", ra, rb, rp);
        end

        check("done_busy_overlap", 64'(overlap), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
